// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        START,
        DATA,
        PARITY,
        STOP
    } uart_tx_state_t;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;

    // Selects the low `bits` bits of a byte so parity ignores unused data bits.
    function automatic logic [7:0] data_mask(input int bits);
        return 8'hFF >> (8 - bits);
    endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmit serializer: frames one byte as start, data (LSB first),
// optional parity and stop bits, advancing one bit per generator tick.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       bit_tick,
    output logic       clk_en,
    output logic       txd,
    output logic       busy,
    output logic       tx_done
);

    localparam logic [2:0] BIT_LAST   = 3'(DATA_BITS - 1);
    localparam logic       STOP_LAST  = 1'(STOP_BITS - 1);
    localparam logic       PAR_INVERT = 1'(PARITY_ODD);
    localparam bit         HAS_PARITY = (PARITY_EN != 0);

    uart_tx_state_t r_state;
    uart_tx_state_t w_state_next;
    logic [7:0]     r_shift;
    logic [7:0]     w_shift_next;
    logic [2:0]     r_bit_cnt;
    logic [2:0]     w_bit_cnt_next;
    logic           r_stop_cnt;
    logic           w_stop_cnt_next;
    logic           r_parity;
    logic           w_parity_next;
    logic           r_txd;
    logic           w_txd_next;
    logic           r_clk_en;
    logic           r_busy;
    logic           r_tx_done;
    logic           w_tx_done_next;

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        w_state_next    = r_state;
        w_shift_next    = r_shift;
        w_bit_cnt_next  = r_bit_cnt;
        w_stop_cnt_next = r_stop_cnt;
        w_parity_next   = r_parity;
        w_tx_done_next  = 1'b0;

        case (r_state)
            IDLE: begin
                if (tx_valid) begin
                    w_state_next  = SYNC;
                    w_shift_next  = tx_data;
                    w_parity_next = (^(tx_data & data_mask(DATA_BITS))) ^ PAR_INVERT;
                end
            end
            SYNC: begin
                if (bit_tick) w_state_next = START;
            end
            START: begin
                if (bit_tick) begin
                    w_state_next   = DATA;
                    w_bit_cnt_next = 3'd0;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    w_shift_next = r_shift >> 1;
                    if (r_bit_cnt == BIT_LAST) begin
                        w_state_next    = HAS_PARITY ? PARITY : STOP;
                        w_stop_cnt_next = 1'b0;
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (bit_tick) begin
                    w_state_next    = STOP;
                    w_stop_cnt_next = 1'b0;
                end
            end
            STOP: begin
                if (bit_tick) begin
                    if (r_stop_cnt == STOP_LAST) begin
                        w_state_next   = IDLE;
                        w_tx_done_next = 1'b1;
                    end else begin
                        w_stop_cnt_next = r_stop_cnt + 1'b1;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase

        // Line level is decoded from where the FSM is going so txd changes with the state.
        case (w_state_next)
            START:   w_txd_next = LINE_START;
            DATA:    w_txd_next = w_shift_next[0];
            PARITY:  w_txd_next = w_parity_next;
            default: w_txd_next = LINE_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_shift    <= 8'h00;
            r_bit_cnt  <= 3'd0;
            r_stop_cnt <= 1'b0;
            r_parity   <= 1'b0;
            r_txd      <= LINE_IDLE;
            r_clk_en   <= 1'b0;
            r_busy     <= 1'b0;
            r_tx_done  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register updating from pre-edge values.
            r_state    <= w_state_next;
            r_shift    <= w_shift_next;
            r_bit_cnt  <= w_bit_cnt_next;
            r_stop_cnt <= w_stop_cnt_next;
            r_parity   <= w_parity_next;
            r_txd      <= w_txd_next;
            r_clk_en   <= (w_state_next != IDLE);
            r_busy     <= (w_state_next != IDLE);
            r_tx_done  <= w_tx_done_next;
        end
    end

    assign tx_ready = (r_state == IDLE);
    assign clk_en   = r_clk_en;
    assign txd      = r_txd;
    assign busy     = r_busy;
    assign tx_done  = r_tx_done;

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmit serializer for the SoC UART peripheral. It accepts one data byte through a valid/ready handshake and frames it as start, data (LSB first), optional parity and stop bits on `txd`. It sits directly downstream of `uart_clock_generator`: it drives that block's `en` input and advances one bit per `rising_edge` pulse it receives back. The UART register block feeds it bytes and observes `busy` and `tx_done`.

## Interface
- `DATA_BITS`, default 8: data bits per frame, legal range 5–8.
- `STOP_BITS`, default 1: number of stop bits, 1 or 2.
- `PARITY_EN`, default 0: 1 inserts a parity bit after the data bits.
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd parity. Ignored when `PARITY_EN` = 0.

- `clk` input 1: system clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `tx_data` input 8: byte to send. Bits [DATA_BITS-1:0] are used.
- `tx_valid` input 1: `tx_data` is valid.
- `tx_ready` output 1: the block can accept a byte.
- `bit_tick` input 1: one-cycle pulse, connected to the generator's `rising_edge`.
- `clk_en` output 1: connected to the generator's `en`.
- `txd` output 1: serial line, idle high.
- `busy` output 1: a frame is in progress.
- `tx_done` output 1: one-cycle pulse when a frame completes.

## Operation
- States (in `uart_pkg`): IDLE, SYNC, START, DATA, PARITY, STOP.
- **IDLE**
  - `tx_ready`=1, `txd`=1, `clk_en`=0, `busy`=0.
  - On `tx_valid && tx_ready`: latch `tx_data` into the shift register, compute parity, go to SYNC.
- **SYNC**
  - `clk_en`=1, `txd`=1.
  - Wait for the first `bit_tick`. This tick only aligns the frame to the generator, because the generator's first tick after enable arrives after half a period.
  - On the tick, go to START.
- **START**
  - `txd`=0.
  - On `bit_tick`, go to DATA with bit counter = 0.
- **DATA**
  - `txd` = shift register LSB.
  - On `bit_tick`: shift right and increment the counter.
  - After `DATA_BITS` ticks, go to PARITY if `PARITY_EN`=1, else to STOP.
- **PARITY**
  - `txd` = XOR of the data bits, inverted when `PARITY_ODD`=1.
  - On `bit_tick`, go to STOP.
- **STOP**
  - `txd`=1.
  - After `STOP_BITS` ticks: go to IDLE, pulse `tx_done` for one cycle, drop `clk_en`. Dropping `clk_en` resets the generator's counter and `sck` to 0.
- Parity is computed over the `DATA_BITS` used bits only.
- Handshake rules:
  - `tx_valid` seen outside IDLE is ignored.
  - The producer holds `tx_valid` and `tx_data` stable until `tx_ready`.
  - Back-to-back frames are allowed: a byte can be accepted in the IDLE cycle immediately after `tx_done`.
- `bit_tick` in IDLE is ignored.
- The generator's `clk_divider_valid` must not be asserted while `busy`=1. This block does not check it.

## Timing
- Reset values: `txd`=1, `tx_ready`=1, `clk_en`=0, `busy`=0, `tx_done`=0, state IDLE.
- Async reset mid-frame forces `txd`=1 immediately and discards the frame. `tx_done` does not pulse.
- `txd`, `clk_en`, `busy` and `tx_done` are registered.
- `tx_ready` is decoded from the state register (IDLE) and has no combinational path from `tx_valid`.
- Latency:
  - Accept in cycle 0 → `clk_en`=1 and `busy`=1 from cycle 1.
  - `txd` falls in the cycle after the SYNC `bit_tick` is sampled.
  - Each later transition takes effect in the cycle after its `bit_tick`.
- Bit period = `bit_tick` period = 2·(`clk_divider`+1) clk cycles.
- Frame length from the SYNC tick to `tx_done` = (1 + `DATA_BITS` + `PARITY_EN` + `STOP_BITS`) bit periods.
- The bit counter is 3 bits wide, with terminal count `DATA_BITS`-1.
- The stop counter is 1 bit wide.

## Structure
- `uart_pkg`:
  - `uart_tx_state_t` enum.
  - Localparams for the idle line level (1) and the start bit level (0).
- Single module with no sub-modules. It is instantiated next to `uart_clock_generator` in the UART top, with `clk_en` → `en` and `rising_edge` → `bit_tick`.
- Receive path and FIFO are separate blocks.

## Test plan
- **Reset:** assert `rst_n`=0 mid-DATA → `txd`=1, `busy`=0 and `tx_ready`=1 immediately; no `tx_done` pulse.
- **8N1 frame:** `clk_divider`=2, send 0xA5 → `txd` = 0,1,0,1,0,0,1,0,1,1, each bit 6 clk cycles wide; `tx_done` pulses 60 cycles after the SYNC tick.
- **Even parity:** `PARITY_EN`=1, `PARITY_ODD`=0, send 0x07 → parity bit 1. Odd parity, send 0x07 → parity bit 0.
- **Two stop bits, 5 data bits:** `STOP_BITS`=2, `DATA_BITS`=5, send 0xFF → the 5 ones are followed by 2 stop bit periods high, then `tx_done`. Bits [7:5] never appear on `txd`.
- **Back-to-back:** hold `tx_valid` with 0x55 then 0xAA → second accept occurs in the cycle after `tx_done`; `txd` stays high through the SYNC alignment, then sends the second start bit.
- **Handshake and stray ticks:** `tx_valid` pulsed during DATA → ignored, and the frame content is unchanged. `bit_tick` pulses while IDLE → `txd` stays 1 and `clk_en` stays 0.
